jtdsp16_ram_ctl: RTL and testbench

Data RAM responder for the DSP16 core: the 2K×16 on-chip data memory and its access controller, sitting on the far side of the RAM address arithmetic unit (YAAU). It accepts the 11-bit indexed address plus read and write strobes once per instruction phase (`ph1`), returns read data on `ram_dout`, and posts writes through a one-entry write buffer with read forwarding. An optional post-reset clear sequencer zeroes the array.

---
 rtl/jtdsp16_pkg.sv | 13 +
 rtl/jtdsp16_ram_mem.sv | 28 ++
 rtl/jtdsp16_ram_ctl.sv | 149 ++++++++++++++
 tb/tb_jtdsp16_ram_ctl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/jtdsp16_pkg.sv
// Shared constants for the DSP16 data RAM: geometry and clear-sequencer state encoding.
// The clear sequencer is only built when JTDSP16_RAM_CLR_EN is defined; its encoding lives here regardless.
package jtdsp16_pkg;

  localparam int RAM_AW    = 11;
  localparam int RAM_DW    = 16;
  localparam int RAM_DEPTH = 1 << RAM_AW;

  // Clear-sequencer states: CLR zeroes the array after reset, READY serves requests.
  localparam logic [0:0] CLR_ST_CLR   = 1'b0;
  localparam logic [0:0] CLR_ST_READY = 1'b1;

endpackage

// File: rtl/jtdsp16_ram_mem.sv
// Plain 2^AW x DW data array: synchronous write port, combinational read port, no reset.
// The controller registers the read result, so the array itself stays a bare storage element.
module jtdsp16_ram_mem
  import jtdsp16_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [0:(1<<AW)-1];

  // Single write port; at most one write per clock.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/jtdsp16_ram_ctl.sv
// DSP16 data RAM controller: phase-qualified read/write requests, one-entry posted
// write buffer with read forwarding, registered read data.
// Optional feature macro: JTDSP16_RAM_CLR_EN adds a post-reset clear sequencer that
// zeroes the whole array and holds busy high for 2^AW cycles.
module jtdsp16_ram_ctl
  import jtdsp16_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ph1,
  input  logic [AW-1:0] ram_addr,
  input  logic          rd_en,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] ram_dout,
  output logic          busy,
  output logic          debug_wb_valid,
  output logic [AW-1:0] debug_wb_addr
);

  logic          busy_s;
  logic          rd_acc_s;
  logic          wr_acc_s;
  logic          commit_s;
  logic          fwd_hit_s;
  logic [DW-1:0] rd_data_s;
  logic [DW-1:0] mem_rdata_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_waddr_s;
  logic [DW-1:0] mem_wdata_s;

  logic          wb_valid_r;
  logic [AW-1:0] wb_addr_r;
  logic [DW-1:0] wb_data_r;
  logic [DW-1:0] ram_dout_r;

`ifdef JTDSP16_RAM_CLR_EN
  logic [0:0]    clr_state_r;
  logic [AW-1:0] clr_cnt_r;

  // Clear sequencer: one zero word per clock from address 0 up to the last word, then READY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_state_r <= CLR_ST_CLR;
      clr_cnt_r   <= {AW{1'b0}};
    end else begin
      case (clr_state_r)
        CLR_ST_CLR: begin
          clr_cnt_r <= clr_cnt_r + {{(AW-1){1'b0}}, 1'b1};
          if (clr_cnt_r == {AW{1'b1}}) begin
            clr_state_r <= CLR_ST_READY;
          end
        end
        CLR_ST_READY: begin
          clr_cnt_r <= clr_cnt_r;
        end
        default: begin
          clr_state_r <= CLR_ST_CLR;
          clr_cnt_r   <= {AW{1'b0}};
        end
      endcase
    end
  end

  assign busy_s = (clr_state_r == CLR_ST_CLR);
`else
  assign busy_s = 1'b0;
`endif

  // Requests count only on phase edges while the array is not being cleared.
  assign rd_acc_s = ph1 && !busy_s && rd_en;
  assign wr_acc_s = ph1 && !busy_s && wr_en;
  // A buffered write drains on the first phase edge after it was captured.
  assign commit_s = ph1 && wb_valid_r;
  assign fwd_hit_s = wb_valid_r && (wb_addr_r == ram_addr);

  // Array write-port arbitration: clear sequencer owns the port while busy, otherwise buffer commit.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = wb_addr_r;
    mem_wdata_s = wb_data_r;
`ifdef JTDSP16_RAM_CLR_EN
    if (busy_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_cnt_r;
      mem_wdata_s = {DW{1'b0}};
    end else begin
      mem_we_s = commit_s;
    end
`else
    mem_we_s = commit_s;
`endif
  end

  // Read source: the pending buffered write shadows the array at its address.
  always_comb begin
    rd_data_s = mem_rdata_s;
    if (fwd_hit_s) begin
      rd_data_s = wb_data_r;
    end else begin
      rd_data_s = mem_rdata_s;
    end
  end

  // Write buffer: capture a new write (older one commits on the same edge) or drain on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_r <= 1'b0;
      wb_addr_r  <= {AW{1'b0}};
      wb_data_r  <= {DW{1'b0}};
    end else if (wr_acc_s) begin
      wb_valid_r <= 1'b1;
      wb_addr_r  <= ram_addr;
      wb_data_r  <= wr_data;
    end else if (commit_s) begin
      wb_valid_r <= 1'b0;
    end
  end

  // Read data register: updated only by an accepted read, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_dout_r <= {DW{1'b0}};
    end else if (rd_acc_s) begin
      ram_dout_r <= rd_data_s;
    end
  end

  jtdsp16_ram_mem #(
    .AW(AW),
    .DW(DW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (mem_waddr_s),
    .wdata (mem_wdata_s),
    .raddr (ram_addr),
    .rdata (mem_rdata_s)
  );

  assign ram_dout       = ram_dout_r;
  assign busy           = busy_s;
  assign debug_wb_valid = wb_valid_r;
  assign debug_wb_addr  = wb_addr_r;

endmodule

// File: tb/tb_jtdsp16_ram_ctl.sv
// Scoreboard bench for jtdsp16_ram_ctl: stimulus pushes expected read data, a monitor
// pops and compares after each accepted read. Clear-sequencer checks follow JTDSP16_RAM_CLR_EN.
module tb_jtdsp16_ram_ctl;

  logic        clk;
  logic        rst_n;
  logic        ph1;
  logic [10:0] ram_addr;
  logic        rd_en;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [15:0] ram_dout;
  logic        busy;
  logic        debug_wb_valid;
  logic [10:0] debug_wb_addr;

  int n_tests;
  int n_fail;
  int rd_fired;
  int rd_seen;
  logic [15:0] sb_q[$];
  logic [15:0] last_exp;

  jtdsp16_ram_ctl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ph1            (ph1),
    .ram_addr       (ram_addr),
    .rd_en          (rd_en),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .ram_dout       (ram_dout),
    .busy           (busy),
    .debug_wb_valid (debug_wb_valid),
    .debug_wb_addr  (debug_wb_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one comparison per accepted read, sampled on the falling edge.
  always @(negedge clk) begin
    if (rd_fired != rd_seen) begin
      rd_seen++;
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_%0d: read with empty scoreboard, got 0x%0h", rd_seen, ram_dout);
      end else begin
        logic [15:0] e;
        e = sb_q.pop_front();
        if (ram_dout !== e) begin
          n_fail++;
          $display("FAIL rd_%0d: ram_dout 0x%0h expected 0x%0h", rd_seen, ram_dout, e);
        end
      end
    end
  end

  task automatic req(input logic r, input logic w, input logic [10:0] a,
                     input logic [15:0] d, input logic [15:0] exp);
    @(negedge clk);
    ph1 = 1'b1; rd_en = r; wr_en = w; ram_addr = a; wr_data = d;
    if (r) begin
      sb_q.push_back(exp);
      last_exp = exp;
    end
    @(posedge clk);
    #1;
    ph1 = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    if (r) rd_fired++;
  endtask

  task automatic wait_clear(input int start);
    int n;
    n = start;
    while (busy && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("clear_len", n, 32'd2048);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; rd_fired = 0; rd_seen = 0; last_exp = 16'h0000;
    rst_n = 1'b0; ph1 = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    ram_addr = 11'h000; wr_data = 16'h0000;
    #2;
    check("rst_dout", ram_dout, 32'h0);
    check("rst_wb_valid", debug_wb_valid, 32'h0);
    check("rst_wb_addr", debug_wb_addr, 32'h0);
`ifdef JTDSP16_RAM_CLR_EN
    check("rst_busy", busy, 32'h1);
    // Start a clear, abort it at cycle 1000 with reset, then run a full clear.
    @(negedge clk); rst_n = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    check("mid_busy", busy, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rerst_busy", busy, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    // Request during busy must be ignored.
    ph1 = 1'b1; rd_en = 1'b1; wr_en = 1'b1; ram_addr = 11'h003; wr_data = 16'hBEEF;
    @(posedge clk); #1;
    ph1 = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    check("busy_ign_wb", debug_wb_valid, 32'h0);
    check("busy_ign_dout", ram_dout, 32'h0);
    wait_clear(1);
    check("ready_busy", busy, 32'h0);
    req(1'b1, 1'b0, 11'h003, 16'h0000, 16'h0000);
    req(1'b1, 1'b0, 11'h7FF, 16'h0000, 16'h0000);
`else
    check("rst_busy", busy, 32'h0);
    @(negedge clk); rst_n = 1'b1;
`endif
    // Forwarding from the buffer before commit.
    req(1'b0, 1'b1, 11'h005, 16'h1234, 16'h0000);
    check("wb_valid_pend", debug_wb_valid, 32'h1);
    check("wb_addr_pend", debug_wb_addr, 32'h005);
    req(1'b1, 1'b0, 11'h005, 16'h0000, 16'h1234);
    check("wb_valid_drained", debug_wb_valid, 32'h0);
    // Back-to-back writes to the same address: later wins.
    req(1'b0, 1'b1, 11'h7FF, 16'hAAAA, 16'h0000);
    req(1'b0, 1'b1, 11'h7FF, 16'h5555, 16'h0000);
    check("wb_valid_2nd", debug_wb_valid, 32'h1);
    req(1'b0, 1'b0, 11'h000, 16'h0000, 16'h0000);
    req(1'b0, 1'b0, 11'h000, 16'h0000, 16'h0000);
    check("wb_valid_idle", debug_wb_valid, 32'h0);
    req(1'b1, 1'b0, 11'h7FF, 16'h0000, 16'h5555);
    // Read-modify-write against committed array content.
    req(1'b0, 1'b1, 11'h010, 16'h0003, 16'h0000);
    req(1'b0, 1'b0, 11'h000, 16'h0000, 16'h0000);
    req(1'b1, 1'b1, 11'h010, 16'h0004, 16'h0003);
    req(1'b1, 1'b0, 11'h010, 16'h0000, 16'h0004);
    // Read-modify-write against a still-pending older write.
    req(1'b0, 1'b1, 11'h020, 16'h0003, 16'h0000);
    req(1'b1, 1'b1, 11'h020, 16'h0009, 16'h0003);
    req(1'b1, 1'b0, 11'h020, 16'h0000, 16'h0009);
    // Requests without ph1 change nothing.
    @(negedge clk);
    rd_en = 1'b1; wr_en = 1'b1; ram_addr = 11'h005; wr_data = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    rd_en = 1'b0; wr_en = 1'b0;
    check("noph1_dout", ram_dout, {16'h0000, last_exp});
    check("noph1_wb", debug_wb_valid, 32'h0);
    req(1'b1, 1'b0, 11'h005, 16'h0000, 16'h1234);
    // Pending write discarded by reset.
    req(1'b0, 1'b1, 11'h030, 16'h0111, 16'h0000);
    req(1'b0, 1'b0, 11'h000, 16'h0000, 16'h0000);
    req(1'b0, 1'b1, 11'h030, 16'h0222, 16'h0000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("disc_wb_valid", debug_wb_valid, 32'h0);
    check("disc_dout", ram_dout, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef JTDSP16_RAM_CLR_EN
    wait_clear(0);
    req(1'b1, 1'b0, 11'h030, 16'h0000, 16'h0000);
`else
    req(1'b1, 1'b0, 11'h030, 16'h0000, 16'h0111);
`endif
    repeat (2) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
